// File: rtl/voltage_disp_pkg.sv
// voltage_disp_pkg
// Shared constants and types for the XADC millivolt display path:
// ASCII code points, BCD sizing, the converter FSM state encoding,
// the packed 4-character word type and a digit-to-ASCII helper.
package voltage_disp_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam int         BCD_DIGITS  = 4;
  localparam int         CONV_ITERS  = 14;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCALE = 2'd1,
    S_CONV  = 2'd2,
    S_DONE  = 2'd3
  } v2a_state_t;

  // [3] is the thousands character, [0] the units character.
  typedef logic [BCD_DIGITS-1:0][7:0] ascii_word_t;

  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Iterative double-dabble binary-to-BCD converter, one bit per clock.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_start     : one-cycle load strobe; captures i_bin, clears BCD and counter
//   i_bin       : binary value to convert (BIN_W bits)
//   o_bcd       : BCD result, valid once o_done has been seen
//   o_done      : high during the final iteration cycle
module bin2bcd_seq
  import voltage_disp_pkg::*;
#(
  parameter int BIN_W = CONV_ITERS,
  parameter int BCD_W = 4 * BCD_DIGITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [BIN_W-1:0] i_bin,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_done
);

  localparam int CNT_W = $clog2(BIN_W);

  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [CNT_W-1:0] r_cnt;
  logic             r_active;
  logic [BCD_W-1:0] w_adj;

  // Add-3 correction on every nibble before the shift.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign o_done = r_active && (r_cnt == CNT_W'(BIN_W - 1));
  assign o_bcd  = r_bcd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_bin    <= i_bin;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
      r_bin <= {r_bin[BIN_W-2:0], 1'b0};
      r_cnt <= r_cnt + 1'b1;
      if (o_done) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/voltage_to_ascii.sv
// voltage_to_ascii
// Turns one raw XADC sample into a packed 4-character millivolt string
// tagged with its XADC channel. One conversion takes 17 clocks; strobes
// that arrive while busy are dropped.
// Optional build macro: VOLTAGE_TO_ASCII_BLANK_EN replaces leading zero
// digits (never the units digit) with spaces.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   adc_data      : raw XADC code, captured with adc_valid
//   adc_channel   : XADC channel address, captured with adc_data
//   adc_valid     : one-cycle sample strobe
//   busy          : conversion in progress
//   ascii_out     : packed characters, [31:24] thousands .. [7:0] units
//   ascii_channel : channel tag belonging to ascii_out
//   ascii_valid   : one-cycle pulse when ascii_out/ascii_channel update
//
// state | meaning
// IDLE  | waiting for adc_valid
// SCALE | raw code -> millivolts, converter loaded
// CONV  | double-dabble iterations running
// DONE  | ASCII word and tag registered, valid pulsed
module voltage_to_ascii
  import voltage_disp_pkg::*;
#(
  parameter int ADC_WIDTH     = 12,
  parameter int FULL_SCALE_MV = 1000,
  parameter int MV_WIDTH      = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADC_WIDTH-1:0] adc_data,
  input  logic [4:0]           adc_channel,
  input  logic                 adc_valid,
  output logic                 busy,
  output logic [31:0]          ascii_out,
  output logic [4:0]           ascii_channel,
  output logic                 ascii_valid
);

  localparam int PROD_W = 26;
  localparam logic [PROD_W-1:0] MV_MAX = PROD_W'(9999);

`ifdef VOLTAGE_TO_ASCII_BLANK_EN
  localparam ascii_word_t RESET_WORD = 32'h20202030;
`else
  localparam ascii_word_t RESET_WORD = 32'h30303030;
`endif

  generate
    if (FULL_SCALE_MV < 1 || FULL_SCALE_MV > 9999) begin : g_bad_fs
      $error("voltage_to_ascii: FULL_SCALE_MV must be in 1..9999");
    end
    if (MV_WIDTH < 14) begin : g_bad_mvw
      $error("voltage_to_ascii: MV_WIDTH must hold 9999");
    end
  endgenerate

  v2a_state_t r_state, w_state_nxt;

  logic [ADC_WIDTH-1:0]    r_raw;
  logic [4:0]              r_chan;
  ascii_word_t             r_ascii_out;
  logic [4:0]              r_ascii_channel;
  logic                    r_ascii_valid;

  logic [PROD_W-1:0]       w_prod;
  logic [PROD_W-1:0]       w_scaled;
  logic [MV_WIDTH-1:0]     w_mv;
  logic                    w_start;
  logic [4*BCD_DIGITS-1:0] w_bcd;
  logic                    w_bcd_done;
  ascii_word_t             w_word;

  // Floor of raw * FS / 2^ADC_WIDTH, clamped in case FS is near 9999.
  assign w_prod   = PROD_W'(r_raw) * PROD_W'(FULL_SCALE_MV);
  assign w_scaled = w_prod >> ADC_WIDTH;
  assign w_mv     = (w_scaled > MV_MAX) ? MV_WIDTH'(MV_MAX) : MV_WIDTH'(w_scaled);
  assign w_start  = (r_state == S_SCALE);

  bin2bcd_seq #(
    .BIN_W (MV_WIDTH),
    .BCD_W (4 * BCD_DIGITS)
  ) u_bin2bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_start),
    .i_bin   (w_mv),
    .o_bcd   (w_bcd),
    .o_done  (w_bcd_done)
  );

  always_comb begin
    for (int i = 0; i < BCD_DIGITS; i++) begin
      w_word[i] = digit_to_ascii(w_bcd[4*i +: 4]);
    end
`ifdef VOLTAGE_TO_ASCII_BLANK_EN
    // Blank from the top down while the higher digits are all zero.
    if (w_bcd[15:12] == 4'd0) w_word[3] = ASCII_SPACE;
    if (w_bcd[15:8]  == 8'd0) w_word[2] = ASCII_SPACE;
    if (w_bcd[15:4]  == 12'd0) w_word[1] = ASCII_SPACE;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (adc_valid) w_state_nxt = S_SCALE;
      S_SCALE: w_state_nxt = S_CONV;
      S_CONV:  if (w_bcd_done) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_raw           <= '0;
      r_chan          <= '0;
      r_ascii_out     <= RESET_WORD;
      r_ascii_channel <= '0;
      r_ascii_valid   <= 1'b0;
    end else begin
      r_ascii_valid <= (r_state == S_DONE);
      if (r_state == S_IDLE && adc_valid) begin
        r_raw  <= adc_data;
        r_chan <= adc_channel;
      end
      if (r_state == S_DONE) begin
        r_ascii_out     <= w_word;
        r_ascii_channel <= r_chan;
      end
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign ascii_out     = r_ascii_out;
  assign ascii_channel = r_ascii_channel;
  assign ascii_valid   = r_ascii_valid;

endmodule

// File: tb/tb_voltage_to_ascii.sv
module tb_voltage_to_ascii;

`ifdef VOLTAGE_TO_ASCII_BLANK_EN
  localparam logic [31:0] E_RST  = 32'h20202030;
  localparam logic [31:0] E_0089 = 32'h20203839;
  localparam logic [31:0] E_0500 = 32'h20353030;
  localparam logic [31:0] E_0999 = 32'h20393939;
  localparam logic [31:0] E_0000 = 32'h20202030;
  localparam logic [31:0] F_0893 = 32'h20383933;
`else
  localparam logic [31:0] E_RST  = 32'h30303030;
  localparam logic [31:0] E_0089 = 32'h30303839;
  localparam logic [31:0] E_0500 = 32'h30353030;
  localparam logic [31:0] E_0999 = 32'h30393939;
  localparam logic [31:0] E_0000 = 32'h30303030;
  localparam logic [31:0] F_0893 = 32'h30383933;
`endif
  localparam logic [31:0] F_4999 = 32'h34393939;
  localparam logic [31:0] F_9996 = 32'h39393936;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] adc_data;
  logic [4:0]  adc_channel;
  logic        adc_valid;
  logic        busy, busy_fs;
  logic [31:0] ascii_out, ascii_out_fs;
  logic [4:0]  ascii_channel, ascii_channel_fs;
  logic        ascii_valid, ascii_valid_fs;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  voltage_to_ascii #(.ADC_WIDTH(12), .FULL_SCALE_MV(1000), .MV_WIDTH(14)) dut (
    .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_channel(adc_channel),
    .adc_valid(adc_valid), .busy(busy), .ascii_out(ascii_out),
    .ascii_channel(ascii_channel), .ascii_valid(ascii_valid)
  );

  voltage_to_ascii #(.ADC_WIDTH(12), .FULL_SCALE_MV(9999), .MV_WIDTH(14)) dut_fs (
    .clk(clk), .rst_n(rst_n), .adc_data(adc_data), .adc_channel(adc_channel),
    .adc_valid(adc_valid), .busy(busy_fs), .ascii_out(ascii_out_fs),
    .ascii_channel(ascii_channel_fs), .ascii_valid(ascii_valid_fs)
  );

  // Strobe for one edge; returns on the falling edge right after acceptance.
  task automatic send(input logic [11:0] raw, input logic [4:0] ch);
    @(negedge clk);
    adc_data    = raw;
    adc_channel = ch;
    adc_valid   = 1'b1;
    @(negedge clk);
    adc_valid   = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_vec++;
      if (ascii_out !== E_RST || ascii_valid !== 1'b0 || busy !== 1'b0 ||
          ascii_channel !== 5'd0) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d: out=%h valid=%b busy=%b ch=%0d, want out=%h valid=0 busy=0 ch=0",
                 c, ascii_out, ascii_valid, busy, ascii_channel, E_RST);
      end
    end
  endtask

  task automatic test_known_values;
    logic [11:0] raws [4] = '{12'd366, 12'd2048, 12'd4095, 12'd0};
    logic [31:0] exps [4] = '{E_0089, E_0500, E_0999, E_0000};
    logic [31:0] fexp [4] = '{F_0893, F_4999, F_9996, E_0000};
    for (int v = 0; v < 4; v++) begin
      int lat;
      lat = 0;
      send(raws[v], 5'd3);
      n_vec++;
      if (busy !== 1'b1) begin
        n_err++;
        $display("FAIL busy_after_accept raw=%0d: busy=%b want 1", raws[v], busy);
      end
      for (int n = 1; n <= 40 && lat == 0; n++) begin
        @(negedge clk);
        if (ascii_valid) lat = n;
      end
      n_vec++;
      if (lat != 16) begin
        n_err++;
        $display("FAIL latency raw=%0d: got %0d want 16 (0 = timeout)", raws[v], lat);
      end
      n_vec++;
      if (ascii_out !== exps[v] || ascii_channel !== 5'd3) begin
        n_err++;
        $display("FAIL value raw=%0d: out=%h ch=%0d want out=%h ch=3",
                 raws[v], ascii_out, ascii_channel, exps[v]);
      end
      n_vec++;
      if (ascii_valid_fs !== 1'b1 || ascii_out_fs !== fexp[v]) begin
        n_err++;
        $display("FAIL fs9999 raw=%0d: valid=%b out=%h want valid=1 out=%h",
                 raws[v], ascii_valid_fs, ascii_out_fs, fexp[v]);
      end
      @(negedge clk);
      n_vec++;
      if (ascii_valid !== 1'b0 || busy !== 1'b0 || ascii_out !== exps[v]) begin
        n_err++;
        $display("FAIL pulse_width raw=%0d: valid=%b busy=%b out=%h want valid=0 busy=0 out=%h",
                 raws[v], ascii_valid, busy, ascii_out, exps[v]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int pulses, t1, t2;
    pulses = 0; t1 = 0; t2 = 0;
    send(12'd4095, 5'd5);
    repeat (4) @(negedge clk);
    adc_data = 12'd0; adc_channel = 5'd7; adc_valid = 1'b1;   // dropped strobe
    @(negedge clk);
    adc_valid = 1'b0;
    for (int n = 6; n <= 50; n++) begin
      @(negedge clk);
      if (adc_valid) adc_valid = 1'b0;
      if (n == 17) begin
        n_vec++;
        if (busy !== 1'b1) begin
          n_err++;
          $display("FAIL accept_on_valid: busy=%b want 1", busy);
        end
      end
      if (ascii_valid) begin
        pulses++;
        if (pulses == 1) begin
          t1 = n;
          n_vec++;
          if (ascii_out !== E_0999 || ascii_channel !== 5'd5) begin
            n_err++;
            $display("FAIL drop_first_value: out=%h ch=%0d want out=%h ch=5",
                     ascii_out, ascii_channel, E_0999);
          end
          adc_data = 12'd2048; adc_channel = 5'd9; adc_valid = 1'b1;
        end else if (pulses == 2) begin
          t2 = n;
          n_vec++;
          if (ascii_out !== E_0500 || ascii_channel !== 5'd9) begin
            n_err++;
            $display("FAIL second_value: out=%h ch=%0d want out=%h ch=9",
                     ascii_out, ascii_channel, E_0500);
          end
        end
      end
    end
    n_vec++;
    if (pulses != 2 || t1 != 16 || t2 != 33) begin
      n_err++;
      $display("FAIL pulse_count: pulses=%0d at %0d,%0d want 2 at 16,33", pulses, t1, t2);
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    pulses = 0;
    send(12'd4095, 5'd2);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (ascii_out !== E_RST || ascii_channel !== 5'd0 || ascii_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: out=%h ch=%0d valid=%b busy=%b want out=%h ch=0 valid=0 busy=0",
               ascii_out, ascii_channel, ascii_valid, busy, E_RST);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (ascii_valid || busy) pulses++;
    end
    n_vec++;
    if (pulses != 0 || ascii_out !== E_RST) begin
      n_err++;
      $display("FAIL abort_no_valid: active_cycles=%0d out=%h want 0 and %h", pulses, ascii_out, E_RST);
    end
  endtask

  initial begin
    rst_n = 1'b0; adc_data = '0; adc_channel = '0; adc_valid = 1'b0;
    test_reset();
    test_known_values();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
